// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encodings, key-schedule sizing, xtime and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_128 = 2'b00,
    MODE_192 = 2'b01,
    MODE_256 = 2'b10,
    MODE_ILL = 2'b11
  } aes_mode_e;

  typedef enum logic [1:0] {
    KE_IDLE,
    KE_EXPAND,
    KE_DRAIN
  } ke_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      MODE_192: return 4'd6;
      MODE_256: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    return nk_of(m) + 4'd6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/ke_subword.sv
// SubWord: four parallel forward S-boxes over a 32-bit schedule word.
module ke_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
    end
  end

endmodule

// File: rtl/ke_iter.sv
// Iterative AES-128/192/256 key expander: one schedule word per cycle,
// packed four at a time into round keys on a valid/ready output.
module ke_iter
  import aes_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [1:0]              mode,
  input  logic [MAX_KEY_BITS-1:0] key,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [127:0]            rk_data,
  output logic [3:0]              rk_idx,
  output logic                    rk_last,
  output logic                    busy,
  output logic                    err
);

  ke_state_e state_q, state_d;

  logic [MAX_KEY_BITS-1:0] key_q, key_d;
  logic [3:0]  nk_q, nk_d, nr_q, nr_d;
  logic [5:0]  last_i_q, last_i_d, i_q, i_d;
  logic [2:0]  wrap_q, wrap_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] win_q [8];
  logic [31:0] win_d [8];
  logic [31:0] coll_q [4];
  logic [31:0] coll_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  ridx_q, ridx_d;
  logic        rk_valid_q, rk_valid_d, rk_last_q, rk_last_d, err_q, err_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic [3:0]  rk_idx_q, rk_idx_d;

  logic        legal, start_hs, out_free, gen, rot, load_out;
  logic [2:0]  far_idx;
  logic [31:0] sub_in, sub_out, t_word, new_word;
  logic [127:0] out_word;

  assign legal    = (mode == MODE_128) ||
                    ((MAX_KEY_BITS == 256) && ((mode == MODE_192) || (mode == MODE_256)));
  assign start_hs = start_valid && (state_q == KE_IDLE);
  assign out_free = !rk_valid_q || rk_ready;
  assign gen      = (state_q == KE_EXPAND) && ((cnt_q != 3'd4) || out_free);
  assign rot      = (wrap_q == 3'd0);
  assign far_idx  = 3'(nk_q - 4'd1);

  // One S-box bank serves both the RotWord and the AES-256 mid-key paths.
  assign sub_in = rot ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

  ke_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    t_word = win_q[0];
    if (rot) begin
      t_word = sub_out ^ {rcon_q, 24'h0};
    end else if ((nk_q == 4'd8) && (wrap_q == 3'd4)) begin
      t_word = sub_out;
    end
    new_word = (i_q < {2'b00, nk_q}) ? key_q[MAX_KEY_BITS-1 -: 32] : (win_q[far_idx] ^ t_word);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      KE_IDLE:   if (start_hs && legal) state_d = KE_EXPAND;
      KE_EXPAND: if (gen && (i_q == last_i_q)) state_d = KE_DRAIN;
      KE_DRAIN:  if (rk_valid_q && rk_ready && rk_last_q) state_d = KE_IDLE;
      default:   state_d = KE_IDLE;
    endcase
  end

  always_comb begin
    key_d    = key_q;
    nk_d     = nk_q;
    nr_d     = nr_q;
    last_i_d = last_i_q;
    i_d      = i_q;
    wrap_d   = wrap_q;
    rcon_d   = rcon_q;
    win_d    = win_q;
    if (start_hs && legal) begin
      key_d    = key;
      nk_d     = nk_of(mode);
      nr_d     = nr_of(mode);
      last_i_d = {nr_of(mode), 2'b11};
      i_d      = '0;
      wrap_d   = '0;
      rcon_d   = RCON_INIT;
    end else if (gen) begin
      key_d  = key_q << 32;
      win_d[0] = new_word;
      for (int unsigned s = 1; s < 8; s++) begin
        win_d[s] = win_q[s-1];
      end
      i_d    = i_q + 6'd1;
      wrap_d = (wrap_q == far_idx) ? 3'd0 : wrap_q + 3'd1;
      if ((i_q >= {2'b00, nk_q}) && rot) rcon_d = xtime(rcon_q);
    end
  end

  // A held full group drains first, freeing slot 0 for this cycle's word; the
  // fourth word of a group bypasses straight to the output when it is free.
  always_comb begin
    coll_d   = coll_q;
    cnt_d    = cnt_q;
    load_out = 1'b0;
    out_word = '0;
    if ((cnt_q == 3'd4) && out_free) begin
      load_out = 1'b1;
      out_word = {coll_q[0], coll_q[1], coll_q[2], coll_q[3]};
      cnt_d    = '0;
    end
    if (gen) begin
      if ((cnt_q == 3'd3) && out_free) begin
        load_out = 1'b1;
        out_word = {coll_q[0], coll_q[1], coll_q[2], new_word};
        cnt_d    = '0;
      end else begin
        coll_d[cnt_d[1:0]] = new_word;
        cnt_d              = cnt_d + 3'd1;
      end
    end
    if (start_hs && legal) cnt_d = '0;
  end

  always_comb begin
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
    rk_last_d  = rk_last_q;
    ridx_d     = ridx_q;
    if (load_out) begin
      rk_valid_d = 1'b1;
      rk_data_d  = out_word;
      rk_idx_d   = ridx_q;
      rk_last_d  = (ridx_q == nr_q);
      ridx_d     = ridx_q + 4'd1;
    end else if (rk_ready) begin
      rk_valid_d = 1'b0;
    end
    if (start_hs && legal) ridx_d = '0;
    err_d = start_hs && !legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= KE_IDLE;
      key_q      <= '0;
      nk_q       <= '0;
      nr_q       <= '0;
      last_i_q   <= '0;
      i_q        <= '0;
      wrap_q     <= '0;
      rcon_q     <= '0;
      win_q      <= '{default: '0};
      coll_q     <= '{default: '0};
      cnt_q      <= '0;
      ridx_q     <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      rk_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      last_i_q   <= last_i_d;
      i_q        <= i_d;
      wrap_q     <= wrap_d;
      rcon_q     <= rcon_d;
      win_q      <= win_d;
      coll_q     <= coll_d;
      cnt_q      <= cnt_d;
      ridx_q     <= ridx_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
      rk_last_q  <= rk_last_d;
      err_q      <= err_d;
    end
  end

  assign start_ready = (state_q == KE_IDLE);
  assign busy        = (state_q != KE_IDLE);
  assign rk_valid    = rk_valid_q;
  assign rk_data     = rk_data_q;
  assign rk_idx      = rk_idx_q;
  assign rk_last     = rk_last_q;
  assign err         = err_q;

endmodule
